// File: rtl/register_dump_reader.sv
// register_dump_reader
// Walks a contiguous, wrapping range of register-file indices through a
// synchronous read port and presents each word, with its index, on a
// valid/ready stream. Only one word is in flight at a time.
// Optional feature macro: REG_DUMP_ABORT_EN adds an ABORT input that drops
// an in-progress dump back to IDLE without a DONE pulse.
module register_dump_reader #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
`ifdef REG_DUMP_ABORT_EN
    input  logic                 ABORT,
`endif
    input  logic                 START,
    input  logic [ADDR_SIZE-1:0] FIRST_ADDR,
    input  logic [ADDR_SIZE-1:0] LAST_ADDR,
    output logic                 RD_EN,
    output logic [ADDR_SIZE-1:0] RD_ADDR,
    input  logic [DATA_SIZE-1:0] RD_DATA,
    output logic [DATA_SIZE-1:0] OUT_DATA,
    output logic [ADDR_SIZE-1:0] OUT_INDEX,
    output logic                 OUT_LAST,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 BUSY,
    output logic                 DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_PRESENT,
        S_FINISH
    } state_t;

    state_t                 state, state_nxt;
    logic [ADDR_SIZE-1:0]   cur_idx;
    logic [ADDR_SIZE-1:0]   end_idx;
    logic                   xfer;
    logic                   abort_req;

    assign xfer = OUT_VALID & OUT_READY;

`ifdef REG_DUMP_ABORT_EN
    // ABORT only matters while a dump is actively walking the range
    assign abort_req = ABORT & ((state == S_ISSUE) | (state == S_CAPTURE) |
                                (state == S_PRESENT));
`else
    assign abort_req = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; abort overrides every in-dump transition
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (START) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_PRESENT;
            S_PRESENT: if (xfer) state_nxt = OUT_LAST ? S_FINISH : S_ISSUE;
            S_FINISH:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (abort_req) state_nxt = S_IDLE;
    end

    // State-decoded outputs; RD_ADDR is parked at 0 outside ISSUE
    always_comb begin
        RD_EN   = (state == S_ISSUE);
        RD_ADDR = (state == S_ISSUE) ? cur_idx : '0;
        BUSY    = (state == S_ISSUE) | (state == S_CAPTURE) | (state == S_PRESENT);
        DONE    = (state == S_FINISH);
    end

    // Range registers, capture of read data and the registered stream outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur_idx   <= '0;
            end_idx   <= '0;
            OUT_DATA  <= '0;
            OUT_INDEX <= '0;
            OUT_LAST  <= 1'b0;
            OUT_VALID <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        cur_idx <= FIRST_ADDR;
                        end_idx <= LAST_ADDR;
                    end
                end
                S_CAPTURE: begin
                    OUT_DATA  <= RD_DATA;
                    OUT_INDEX <= cur_idx;
                    OUT_LAST  <= (cur_idx == end_idx);
                    OUT_VALID <= 1'b1;
                end
                S_PRESENT: begin
                    if (xfer) begin
                        OUT_VALID <= 1'b0;
                        // Natural wrap at 2^ADDR_SIZE gives the FIRST>LAST case
                        if (!OUT_LAST) cur_idx <= cur_idx + 1'b1;
                    end
                end
                default: ;
            endcase
            if (abort_req) begin
                OUT_VALID <= 1'b0;
                OUT_LAST  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_register_dump_reader.sv
// Directed testbench for register_dump_reader with a behavioural register
// file (synchronous read, Rn = 0x1000_0000 + n).
module tb_register_dump_reader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [3:0]  FIRST_ADDR = '0;
    logic [3:0]  LAST_ADDR = '0;
    logic        RD_EN;
    logic [3:0]  RD_ADDR;
    logic [31:0] RD_DATA = '0;
    logic [31:0] OUT_DATA;
    logic [3:0]  OUT_INDEX;
    logic        OUT_LAST;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic        BUSY;
    logic        DONE;
`ifdef REG_DUMP_ABORT_EN
    logic        ABORT = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int rd_total = 0;
    int done_total = 0;
    logic [31:0] rf [16];

    register_dump_reader #(.DATA_SIZE(32), .ADDR_SIZE(4)) dut (
        .CLK(CLK),
        .RST(RST),
`ifdef REG_DUMP_ABORT_EN
        .ABORT(ABORT),
`endif
        .START(START),
        .FIRST_ADDR(FIRST_ADDR),
        .LAST_ADDR(LAST_ADDR),
        .RD_EN(RD_EN),
        .RD_ADDR(RD_ADDR),
        .RD_DATA(RD_DATA),
        .OUT_DATA(OUT_DATA),
        .OUT_INDEX(OUT_INDEX),
        .OUT_LAST(OUT_LAST),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Register file model: data appears the cycle after the read strobe
    always @(posedge CLK) if (RD_EN) RD_DATA <= rf[RD_ADDR];

    // Pulse counters sampled mid-cycle, away from the active edge
    always @(negedge CLK) begin
        if (RD_EN) rd_total <= rd_total + 1;
        if (DONE)  done_total <= done_total + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one full dump, checking every cycle of the walk against the
    // expected index sequence; optionally stalls one index and pokes START
    // while busy and during FINISH.
    task automatic run_dump(input logic [3:0] f, input logic [3:0] l,
                            input int stall_idx, input int stall_len,
                            input bit poke_start);
        logic [3:0] idx;
        int rd_base, done_base, nwords;
        bit finished;
        rd_base = rd_total;
        done_base = done_total;
        START = 1'b1; FIRST_ADDR = f; LAST_ADDR = l; OUT_READY = 1'b1;
        tick();
        START = 1'b0;
        idx = f;
        nwords = 0;
        finished = 1'b0;
        for (int w = 0; w < 17; w++) begin
            chk("issue_rd_en", RD_EN, 1'b1);
            chk("issue_rd_addr", RD_ADDR, idx);
            chk("issue_busy", BUSY, 1'b1);
            tick();
            chk("capture_rd_en", RD_EN, 1'b0);
            chk("capture_valid", OUT_VALID, 1'b0);
            tick();
            nwords++;
            chk("present_valid", OUT_VALID, 1'b1);
            chk("present_data", OUT_DATA, 32'h1000_0000 + 32'(idx));
            chk("present_index", OUT_INDEX, idx);
            chk("present_last", OUT_LAST, idx == l);
            if (int'(idx) == stall_idx) begin
                OUT_READY = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    chk("stall_valid", OUT_VALID, 1'b1);
                    chk("stall_data", OUT_DATA, 32'h1000_0000 + 32'(idx));
                    chk("stall_index", OUT_INDEX, idx);
                    chk("stall_rd_en", RD_EN, 1'b0);
                end
                OUT_READY = 1'b1;
            end
            if (poke_start) begin
                START = 1'b1; FIRST_ADDR = 4'd0; LAST_ADDR = 4'd5;
            end
            tick();
            if (idx == l) begin
                finished = 1'b1;
                break;
            end
            idx = idx + 4'd1;
        end
        chk("dump_terminated", finished, 1'b1);
        chk("finish_done", DONE, 1'b1);
        chk("finish_busy", BUSY, 1'b0);
        chk("finish_valid", OUT_VALID, 1'b0);
        tick();
        START = 1'b0;
        chk("idle_done", DONE, 1'b0);
        chk("idle_rd_en", RD_EN, 1'b0);
        chk("idle_busy", BUSY, 1'b0);
        tick();
        chk("idle_stays", BUSY, 1'b0);
        chk("rd_pulses", rd_total - rd_base, nwords);
        chk("done_pulses", done_total - done_base, 1);
    endtask

    // Starts FIRST=0 LAST=5 and stops with index 2 presented and stalled
    task automatic walk_to_index2();
        bit found;
        START = 1'b1; FIRST_ADDR = 4'd0; LAST_ADDR = 4'd5; OUT_READY = 1'b1;
        tick();
        START = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (OUT_VALID && OUT_INDEX == 4'd2) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        OUT_READY = 1'b0;
        chk("reach_index2", found, 1'b1);
    endtask

    initial begin
        int done_base;
        for (int n = 0; n < 16; n++) rf[n] = 32'h1000_0000 + 32'(n);

        // Reset with junk on the inputs
        START = 1'b1; FIRST_ADDR = 4'd9; LAST_ADDR = 4'd3; OUT_READY = 1'b1;
        #3;
        chk("rst_rd_en", RD_EN, 1'b0);
        chk("rst_rd_addr", RD_ADDR, 4'd0);
        chk("rst_out_data", OUT_DATA, 32'd0);
        chk("rst_out_index", OUT_INDEX, 4'd0);
        chk("rst_out_last", OUT_LAST, 1'b0);
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        tick();
        START = 1'b0; RST = 1'b0;
        tick();
        chk("post_rst_idle", BUSY, 1'b0);

        // Basic ascending dump
        run_dump(4'd0, 4'd3, -1, 0, 1'b0);
        // Backpressure on index 1
        run_dump(4'd0, 4'd3, 1, 5, 1'b0);
        // Wrap 14,15,0,1
        run_dump(4'd14, 4'd1, -1, 0, 1'b0);
        // Single word, START poked during PRESENT and FINISH
        run_dump(4'd7, 4'd7, -1, 0, 1'b1);

        // Asynchronous reset mid-dump while index 2 is presented
        done_base = done_total;
        walk_to_index2();
        #2 RST = 1'b1;
        #1;
        chk("async_rst_valid", OUT_VALID, 1'b0);
        chk("async_rst_data", OUT_DATA, 32'd0);
        chk("async_rst_index", OUT_INDEX, 4'd0);
        chk("async_rst_busy", BUSY, 1'b0);
        chk("async_rst_rd_en", RD_EN, 1'b0);
        tick();
        RST = 1'b0; OUT_READY = 1'b1;
        repeat (4) tick();
        chk("after_rst_valid", OUT_VALID, 1'b0);
        chk("after_rst_no_done", done_total - done_base, 0);
        run_dump(4'd0, 4'd3, -1, 0, 1'b0);

`ifdef REG_DUMP_ABORT_EN
        // Abort while index 2 is presented
        done_base = done_total;
        walk_to_index2();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort_valid", OUT_VALID, 1'b0);
        chk("abort_last", OUT_LAST, 1'b0);
        chk("abort_busy", BUSY, 1'b0);
        OUT_READY = 1'b1;
        repeat (4) tick();
        chk("abort_no_done", done_total - done_base, 0);
        run_dump(4'd0, 4'd3, -1, 0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/register_dump_reader.md
Name: register_dump_reader

Overview:
Reader-side companion to the processor's clocked data registers and register file. On a START request it walks a contiguous, wrapping range of register indices through the register file's synchronous read port. It presents each word on a valid/ready stream with its index, which feeds the debug/trace path. It holds one word at a time and applies full backpressure.

Parameters:
DATA_SIZE, 32, width of each register word
ADDR_SIZE, 4, width of a register index (16 registers, R0..R15)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous reset, active-high
START  input  1  request a dump; sampled only in IDLE
FIRST_ADDR  input  ADDR_SIZE  first index to read; sampled with START
LAST_ADDR  input  ADDR_SIZE  last index to read, inclusive; sampled with START
RD_EN  output  1  read strobe to register file
RD_ADDR  output  ADDR_SIZE  read index to register file
RD_DATA  input  DATA_SIZE  register file data; valid the cycle after RD_EN
OUT_DATA  output  DATA_SIZE  presented register word
OUT_INDEX  output  ADDR_SIZE  index of OUT_DATA
OUT_LAST  output  1  marks final word of the dump
OUT_VALID  output  1  stream valid
OUT_READY  input  1  stream ready from consumer
BUSY  output  1  dump in progress
DONE  output  1  one-cycle pulse on completion

Behaviour:
- Reset (RST high, asynchronous): state IDLE; cur/end index registers 0; all outputs 0 (RD_EN, RD_ADDR, OUT_DATA, OUT_INDEX, OUT_LAST, OUT_VALID, BUSY, DONE).
- FSM states and outputs:
  - IDLE: BUSY=0. START=1 latches cur<=FIRST_ADDR, end<=LAST_ADDR, then -> ISSUE.
  - ISSUE: RD_EN=1, RD_ADDR=cur, BUSY=1. Next state CAPTURE.
  - CAPTURE: RD_EN=0, BUSY=1. At the closing edge, OUT_DATA<=RD_DATA, OUT_INDEX<=cur, OUT_LAST<=(cur==end), OUT_VALID<=1. Next state PRESENT.
  - PRESENT: OUT_VALID=1, BUSY=1.
    - Transfer = OUT_VALID & OUT_READY at the edge.
    - On transfer with OUT_LAST=1: OUT_VALID<=0, -> FINISH.
    - On transfer otherwise: OUT_VALID<=0, cur<=cur+1 modulo 2^ADDR_SIZE, -> ISSUE.
    - Without transfer: OUT_DATA, OUT_INDEX, OUT_LAST stay stable; no RD_EN.
  - FINISH: DONE=1 for exactly one cycle, BUSY=0. Next state IDLE.
- Latency: START sampled at edge N -> RD_EN high in cycle N+1 -> OUT_VALID first high in cycle N+3. With OUT_READY tied high, one word every 3 cycles.
- OUT_VALID, OUT_DATA, OUT_INDEX and OUT_LAST are registered. None has a combinational path from OUT_READY.
- Range and wrap:
  - FIRST_ADDR<=LAST_ADDR: reads ascending.
  - FIRST_ADDR>LAST_ADDR: reads FIRST..2^ADDR_SIZE-1, wraps to 0, continues to LAST.
  - FIRST_ADDR==LAST_ADDR: exactly one word, with OUT_LAST=1.
- START outside IDLE (including FINISH) is ignored; range inputs are not re-sampled.
- Exactly one RD_EN pulse per word; no speculative reads.
- RST during any state: outputs clear immediately, no DONE, partial dump discarded.

Optional Feature:
Macro REG_DUMP_ABORT_EN.
- Defined: adds input ABORT (1 bit).
  - ABORT=1 in ISSUE, CAPTURE or PRESENT -> next state IDLE.
  - OUT_VALID<=0, OUT_LAST<=0, BUSY<=0. DONE is not pulsed.
  - A transfer coinciding with ABORT still counts as consumed.
  - ABORT in IDLE or FINISH has no effect.
- Undefined: no ABORT port; a dump always runs to completion or reset.

Test Plan:
- Reset: assert RST mid-cycle with random inputs -> all outputs 0 asynchronously; state IDLE after release.
- Basic dump: Rn=0x1000_0000+n, FIRST=0, LAST=3, OUT_READY=1, START at edge N -> first OUT_VALID in cycle N+3. Words 0x10000000..0x10000003 with OUT_INDEX 0..3, spaced 3 cycles. OUT_LAST only on index 3. DONE one cycle after the last transfer; 4 RD_EN pulses total.
- Backpressure: same setup, OUT_READY low 5 cycles while index 1 is presented -> OUT_DATA=0x10000001 and OUT_INDEX=1 held stable, no RD_EN during stall. Sequence resumes on ready.
- Wrap: FIRST=14, LAST=1 -> indices 14,15,0,1 in order; OUT_LAST on index 1.
- Single word and START while busy: FIRST=LAST=7 -> one word, OUT_LAST=1. Second START pulsed during PRESENT -> ignored, only one DONE.
- Mid-dump RST (and ABORT when REG_DUMP_ABORT_EN defined): interrupt in PRESENT at index 2 -> OUT_VALID=0 next, no DONE. Fresh START afterwards dumps correctly from FIRST.
